// File: rtl/pkmc_sdram_bank_sched_if.sv
// rtl/pkmc_sdram_bank_sched_if.sv - command/query bus between controller FSM and bank scheduler
interface pkmc_sdram_bank_sched_if #(
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13
);
  logic              cmd_valid_i;
  logic [2:0]        cmd_i;
  logic [BANK_W-1:0] cmd_bank_i;
  logic [ROW_W-1:0]  cmd_row_i;
  logic [BANK_W-1:0] req_bank_i;
  logic [ROW_W-1:0]  req_row_i;
  logic              init_i;
  logic              irq_ack_i;
  logic              row_hit_o;
  logic              bank_open_o;
  logic              pch_ok_o;
  logic              act_ok_o;
  logic              all_one_o;
  logic              any_open_o;
  logic              ref_ok_o;
  logic              err_o;

  modport master (
    output cmd_valid_i, cmd_i, cmd_bank_i, cmd_row_i,
    output req_bank_i, req_row_i, init_i, irq_ack_i,
    input  row_hit_o, bank_open_o, pch_ok_o, act_ok_o,
    input  all_one_o, any_open_o, ref_ok_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, cmd_bank_i, cmd_row_i,
    input  req_bank_i, req_row_i, init_i, irq_ack_i,
    output row_hit_o, bank_open_o, pch_ok_o, act_ok_o,
    output all_one_o, any_open_o, ref_ok_o, err_o
  );
endinterface

// File: rtl/pkmc_sdram_bank_sched.sv
// rtl/pkmc_sdram_bank_sched.sv - per-bank open/row/tRAS/tRP tracker and precharge-mode scheduler
module pkmc_sdram_bank_sched #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int ROW_W     = 13,
  parameter int TRAS      = 5,
  parameter int TRP       = 2,
  parameter int CNT_W     = 4
) (
  input logic clk_i,
  input logic rst_i,
  pkmc_sdram_bank_sched_if.slave bus
);

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_ACT     = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_WR      = 3'd3;
  localparam logic [2:0] CMD_PCH_ONE = 3'd4;
  localparam logic [2:0] CMD_PCH_ALL = 3'd5;
  localparam logic [2:0] CMD_REF     = 3'd6;

  localparam logic [CNT_W-1:0] TRAS_LD = CNT_W'(TRAS - 1);
  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'(TRP - 1);

  logic             open_q [NUM_BANKS];
  logic [ROW_W-1:0] row_q  [NUM_BANKS];
  logic [CNT_W-1:0] tras_q [NUM_BANKS];
  logic [CNT_W-1:0] trp_q  [NUM_BANKS];
  logic             err_q;

  logic cmd_act, cmd_pch_one, cmd_pch_all, cmd_ref;
  logic any_open, multi_open, all_trp_idle, open_busy, ref_ok;
  logic act_err, pch_one_err, pch_all_err, ref_err;

  // RD, WR, NOP and the reserved code all leave bank state untouched.
  always_comb begin
    cmd_act     = 1'b0;
    cmd_pch_one = 1'b0;
    cmd_pch_all = 1'b0;
    cmd_ref     = 1'b0;
    if (bus.cmd_valid_i) begin
      case (bus.cmd_i)
        CMD_ACT:     cmd_act     = 1'b1;
        CMD_PCH_ONE: cmd_pch_one = 1'b1;
        CMD_PCH_ALL: cmd_pch_all = 1'b1;
        CMD_REF:     cmd_ref     = 1'b1;
        CMD_NOP, CMD_RD, CMD_WR: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    any_open     = 1'b0;
    multi_open   = 1'b0;
    all_trp_idle = 1'b1;
    open_busy    = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (open_q[i]) begin
        if (any_open) multi_open = 1'b1;
        any_open = 1'b1;
        if (tras_q[i] != '0) open_busy = 1'b1;
      end
      if (trp_q[i] != '0) all_trp_idle = 1'b0;
    end
  end

  assign ref_ok = !any_open && all_trp_idle;

  assign act_err     = cmd_act && (open_q[bus.cmd_bank_i] || trp_q[bus.cmd_bank_i] != '0);
  assign pch_one_err = cmd_pch_one && open_q[bus.cmd_bank_i] && tras_q[bus.cmd_bank_i] != '0;
  assign pch_all_err = cmd_pch_all && open_busy;
  assign ref_err     = cmd_ref && !ref_ok;

  // Command loads override the per-cycle saturating decrement; violations still update state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
        tras_q[i] <= '0;
        trp_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (tras_q[i] != '0) tras_q[i] <= tras_q[i] - 1'b1;
        if (trp_q[i] != '0) trp_q[i] <= trp_q[i] - 1'b1;
        if (cmd_act && bus.cmd_bank_i == BANK_W'(i)) begin
          open_q[i] <= 1'b1;
          row_q[i]  <= bus.cmd_row_i;
          tras_q[i] <= TRAS_LD;
        end
        if (cmd_pch_all || (cmd_pch_one && bus.cmd_bank_i == BANK_W'(i))) begin
          open_q[i] <= 1'b0;
          trp_q[i]  <= TRP_LD;
        end
      end
      if (act_err || pch_one_err || pch_all_err || ref_err) err_q <= 1'b1;
    end
  end

  assign bus.bank_open_o = open_q[bus.req_bank_i];
  assign bus.row_hit_o   = open_q[bus.req_bank_i] && row_q[bus.req_bank_i] == bus.req_row_i;
  assign bus.pch_ok_o    = open_q[bus.req_bank_i] && tras_q[bus.req_bank_i] == '0;
  assign bus.act_ok_o    = !open_q[bus.req_bank_i] && trp_q[bus.req_bank_i] == '0;
  assign bus.any_open_o  = any_open;
  assign bus.ref_ok_o    = ref_ok;
  assign bus.err_o       = err_q;
  // Initialisation and refresh always close everything; otherwise PCH_ALL only pays off with 2+ open.
  assign bus.all_one_o   = bus.init_i || bus.irq_ack_i || (any_open && multi_open);

endmodule
